// File: rtl/dram_ctrl.sv
// dram_ctrl: host-side command controller for the 32x32 single-port DRAM model.
// Accepts valid/ready read/write requests, drives the DRAM cs/rw/oe command
// encoding from registers, returns read data as a one-cycle response pulse and
// optionally inserts periodic refresh commands.
//
// Optional feature macro: DRAM_CTRL_REFRESH_EN (refresh timer + REF state).
// When undefined, dram_refresh is tied to 000, ref_busy to 0 and the refresh
// parameters have no effect.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   host request handshake
//   req_we            1 = write, 0 = read
//   req_addr[9:0]     [9:5] row, [4:0] column
//   req_wdata[31:0]   write data
//   rsp_valid         one-cycle read response strobe
//   rsp_rdata[31:0]   read data, held until the next capture
//   dram_cs/rw/oe     DRAM command encoding
//   dram_row/col      DRAM address
//   dram_wdata        DRAM write data
//   dram_rdata        DRAM read data
//   dram_refresh      refresh strobe (001 while refreshing)
//   ref_busy          high while in the REF state
module dram_ctrl #(
    parameter int unsigned REFRESH_INTERVAL = 64,
    parameter int unsigned REFRESH_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [2:0]  dram_cs,
    output logic [2:0]  dram_rw,
    output logic [1:0]  dram_oe,
    output logic [4:0]  dram_row,
    output logic [4:0]  dram_col,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    output logic [2:0]  dram_refresh,
    output logic        ref_busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR     = 3'd1,
        S_RD     = 3'd2,
        S_RD_CAP = 3'd3
`ifdef DRAM_CTRL_REFRESH_EN
        ,
        S_REF    = 3'd4
`endif
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       accept;
    logic [2:0] cs_nx;
    logic [2:0] rw_nx;
    logic [1:0] oe_nx;

`ifdef DRAM_CTRL_REFRESH_EN
    localparam logic [15:0] IntervalLoad = 16'(REFRESH_INTERVAL - 1);
    localparam logic [3:0]  CyclesLoad   = 4'(REFRESH_CYCLES - 1);

    logic [15:0] ref_timer;
    logic [3:0]  ref_left;
    logic        ref_pending;
    logic        ref_enter;

    assign req_ready = (state == S_IDLE) && !ref_pending;
    assign ref_enter = (state == S_IDLE) && ref_pending;
    assign ref_busy  = (state == S_REF);
`else
    assign req_ready    = (state == S_IDLE);
    assign dram_refresh = 3'b000;
    assign ref_busy     = 1'b0;

    // Refresh parameters are accepted but unused in this build.
    if (REFRESH_INTERVAL == 0 || REFRESH_CYCLES == 0) begin : g_no_refresh
    end
`endif

    // Next-state logic. Refresh wins over a request in the same IDLE cycle
    // because req_ready is already low while ref_pending is set.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        unique case (state)
            S_IDLE: begin
`ifdef DRAM_CTRL_REFRESH_EN
                if (ref_pending) begin
                    state_nx = S_REF;
                end else
`endif
                if (req_valid) begin
                    accept   = 1'b1;
                    state_nx = req_we ? S_WR : S_RD;
                end
            end
            S_WR:     state_nx = S_IDLE;
            S_RD:     state_nx = S_RD_CAP;
            S_RD_CAP: state_nx = S_IDLE;
`ifdef DRAM_CTRL_REFRESH_EN
            S_REF: begin
                if (ref_left == 4'd0) begin
                    state_nx = S_IDLE;
                end
            end
`endif
            default:  state_nx = S_IDLE;
        endcase
    end

    // Command pins are registered: decode the state being entered.
    always_comb begin
        cs_nx = 3'b000;
        rw_nx = 3'b000;
        oe_nx = 2'b00;
        unique case (state_nx)
            S_WR: begin
                cs_nx = 3'b001;
                rw_nx = 3'b010;
                oe_nx = 2'b10;
            end
            S_RD: begin
                cs_nx = 3'b001;
                rw_nx = 3'b001;
                oe_nx = 2'b01;
            end
`ifdef DRAM_CTRL_REFRESH_EN
            S_REF: begin
                cs_nx = 3'b001;
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            dram_cs    <= 3'b000;
            dram_rw    <= 3'b000;
            dram_oe    <= 2'b00;
            dram_row   <= 5'd0;
            dram_col   <= 5'd0;
            dram_wdata <= 32'd0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= 32'd0;
        end else begin
            state   <= state_nx;
            dram_cs <= cs_nx;
            dram_rw <= rw_nx;
            dram_oe <= oe_nx;
            if (accept) begin
                dram_row <= req_addr[9:5];
                dram_col <= req_addr[4:0];
                if (req_we) begin
                    dram_wdata <= req_wdata;
                end
            end
            // DRAM data registered at the end of RD is stable in RD_CAP.
            rsp_valid <= (state == S_RD_CAP);
            if (state == S_RD_CAP) begin
                rsp_rdata <= dram_rdata;
            end
        end
    end

`ifdef DRAM_CTRL_REFRESH_EN
    // Free-running refresh timer; it never pauses, so the request rate stays
    // fixed regardless of traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_timer    <= IntervalLoad;
            ref_pending  <= 1'b0;
            ref_left     <= 4'd0;
            dram_refresh <= 3'b000;
        end else begin
            if (ref_timer == 16'd0) begin
                ref_timer <= IntervalLoad;
            end else begin
                ref_timer <= ref_timer - 16'd1;
            end

            if (ref_timer == 16'd0) begin
                ref_pending <= 1'b1;
            end else if (ref_enter) begin
                ref_pending <= 1'b0;
            end

            if (ref_enter) begin
                ref_left <= CyclesLoad;
            end else if (state == S_REF && ref_left != 4'd0) begin
                ref_left <= ref_left - 4'd1;
            end

            dram_refresh <= (state_nx == S_REF) ? 3'b001 : 3'b000;
        end
    end
`endif

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: self-checking bench for dram_ctrl with a behavioural DRAM
// model and a read-response scoreboard.
module tb_dram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [9:0]  req_addr = 10'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [2:0]  dram_cs;
    logic [2:0]  dram_rw;
    logic [1:0]  dram_oe;
    logic [4:0]  dram_row;
    logic [4:0]  dram_col;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [2:0]  dram_refresh;
    logic        ref_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mem       [0:1023];
    logic [31:0] model_mem [0:1023];
    logic [31:0] exp_q [$];
    int          lat_q [$];

    dram_ctrl #(
        .REFRESH_INTERVAL(8),
        .REFRESH_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .dram_cs(dram_cs),
        .dram_rw(dram_rw),
        .dram_oe(dram_oe),
        .dram_row(dram_row),
        .dram_col(dram_col),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .dram_refresh(dram_refresh),
        .ref_busy(ref_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // DRAM model: samples the command at the clock edge, registers read data.
    always @(posedge clk) begin
        if (dram_cs == 3'b001 && dram_rw == 3'b010)
            mem[{dram_row, dram_col}] <= dram_wdata;
        if (dram_cs == 3'b001 && dram_rw == 3'b001)
            dram_rdata <= mem[{dram_row, dram_col}];
    end

    // Advance to the next falling edge and score any read response.
    task automatic tick();
        @(negedge clk);
        if (rsp_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: rsp_valid=1 at cycle %0d, no read outstanding", cyc);
            end else begin
                logic [31:0] e;
                int          t;
                e = exp_q.pop_front();
                t = lat_q.pop_front();
                if (rsp_rdata !== e) begin
                    errors++;
                    $display("FAIL rsp_data: got %h, required %h", rsp_rdata, e);
                end
                checks++;
                if (cyc !== t + 2) begin
                    errors++;
                    $display("FAIL rsp_latency: rsp at cycle %0d, required %0d", cyc, t + 2);
                end
            end
        end
    endtask

    // Called at a falling edge where the request will be accepted next edge.
    task automatic record(input logic we, input logic [9:0] addr, input logic [31:0] data);
        if (we) begin
            model_mem[addr] = data;
        end else begin
            exp_q.push_back(model_mem[addr]);
            lat_q.push_back(cyc + 1);
        end
    endtask

    // Present a request and return at the falling edge after acceptance.
    task automatic issue(input logic we, input logic [9:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: req_ready=%b after %0d cycles, required 1", req_ready, n);
            req_valid = 1'b0;
        end else begin
            record(we, addr, data);
            tick();
            req_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d reads outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic apply_reset();
        req_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({dram_cs, dram_rw, dram_oe, dram_refresh} !== 11'd0) begin
            errors++;
            $display("FAIL reset_cmd: cs=%b rw=%b oe=%b refresh=%b, required all 0",
                     dram_cs, dram_rw, dram_oe, dram_refresh);
        end
        checks++;
        if ({dram_row, dram_col, dram_wdata} !== 42'd0) begin
            errors++;
            $display("FAIL reset_addr: row=%h col=%h wdata=%h, required 0",
                     dram_row, dram_col, dram_wdata);
        end
        checks++;
        if ({rsp_valid, rsp_rdata, ref_busy} !== 34'd0) begin
            errors++;
            $display("FAIL reset_rsp: rsp_valid=%b rdata=%h ref_busy=%b, required 0",
                     rsp_valid, rsp_rdata, ref_busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b, required 1", req_ready);
        end
        tick();
    endtask

    task automatic test_write_read();
        issue(1'b1, 10'h005, 32'hDEADBEEF);
        checks++;
        if ({dram_cs, dram_rw, dram_oe} !== {3'b001, 3'b010, 2'b10}) begin
            errors++;
            $display("FAIL wr_cmd: cs=%b rw=%b oe=%b, required 001 010 10",
                     dram_cs, dram_rw, dram_oe);
        end
        checks++;
        if ({dram_row, dram_col, dram_wdata} !== {5'd0, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL wr_addr: row=%0d col=%0d wdata=%h, required 0 5 deadbeef",
                     dram_row, dram_col, dram_wdata);
        end
        tick();
        checks++;
        if ({dram_cs, dram_rw, dram_oe} !== 8'd0) begin
            errors++;
            $display("FAIL wr_one_cycle: cs=%b rw=%b oe=%b, required idle",
                     dram_cs, dram_rw, dram_oe);
        end
`ifndef DRAM_CTRL_REFRESH_EN
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_ready_back: req_ready=%b, required 1", req_ready);
        end
`endif
        issue(1'b0, 10'h005, 32'd0);
        checks++;
        if ({dram_cs, dram_rw, dram_oe} !== {3'b001, 3'b001, 2'b01}) begin
            errors++;
            $display("FAIL rd_cmd: cs=%b rw=%b oe=%b, required 001 001 01",
                     dram_cs, dram_rw, dram_oe);
        end
        tick();
        checks++;
        if ({dram_cs, dram_rw, dram_oe, req_ready} !== 9'd0) begin
            errors++;
            $display("FAIL rd_cap: cs=%b rw=%b oe=%b ready=%b, required idle and 0",
                     dram_cs, dram_rw, dram_oe, req_ready);
        end
        drain("write_read");
    endtask

    task automatic test_back_to_back();
        logic        op_we   [8];
        logic [9:0]  op_addr [8];
        logic [31:0] op_data [8];
        bit          obs [$];
        bit          exp_r [$];
        int          k;
        int          n;
        for (int i = 0; i < 8; i++) begin
            op_we[i]   = (i % 2 == 0);
            op_addr[i] = 10'(i / 2);
            op_data[i] = 32'(i / 2 + 1);
            exp_r.push_back(1'b1);
            exp_r.push_back(1'b0);
            if (!op_we[i]) exp_r.push_back(1'b0);
        end
        exp_r.push_back(1'b1);
        k = 0;
        n = 0;
        req_valid = 1'b1;
        req_we    = op_we[0];
        req_addr  = op_addr[0];
        req_wdata = op_data[0];
        while (k < 8 && n < 80) begin
            obs.push_back(req_ready);
            if (req_ready === 1'b1) begin
                record(op_we[k], op_addr[k], op_data[k]);
                k++;
            end
            tick();
            n++;
            if (k < 8) begin
                req_we    = op_we[k];
                req_addr  = op_addr[k];
                req_wdata = op_data[k];
            end
        end
        req_valid = 1'b0;
        checks++;
        if (k != 8) begin
            errors++;
            $display("FAIL b2b_accept: accepted %0d requests, required 8", k);
        end
        for (int i = 0; i < 3; i++) begin
            obs.push_back(req_ready);
            if (i < 2) tick();
        end
        drain("b2b");
`ifndef DRAM_CTRL_REFRESH_EN
        checks++;
        if (obs.size() != exp_r.size()) begin
            errors++;
            $display("FAIL b2b_ready_len: %0d samples, required %0d", obs.size(), exp_r.size());
        end else begin
            for (int i = 0; i < obs.size(); i++) begin
                checks++;
                if (obs[i] !== exp_r[i]) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %b, required %b", i, obs[i], exp_r[i]);
                end
            end
        end
`endif
    endtask

    task automatic test_reset_mid_read();
        issue(1'b0, 10'h002, 32'd0);
        checks++;
        if ({dram_cs, dram_rw, dram_oe} !== {3'b001, 3'b001, 2'b01}) begin
            errors++;
            $display("FAIL rst_rd_cmd: cs=%b rw=%b oe=%b, required 001 001 01",
                     dram_cs, dram_rw, dram_oe);
        end
        #2;
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        #1;
        checks++;
        if ({dram_cs, dram_rw, dram_oe, dram_refresh, dram_row, dram_col, dram_wdata} !== 53'd0) begin
            errors++;
            $display("FAIL rst_async: cs=%b rw=%b oe=%b row=%h col=%h wdata=%h, required 0",
                     dram_cs, dram_rw, dram_oe, dram_row, dram_col, dram_wdata);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready: req_ready=%b, required 1", req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_no_rsp: rsp_valid=%b at step %0d, required 0", rsp_valid, i);
            end
        end
    endtask

`ifndef DRAM_CTRL_REFRESH_EN
    task automatic test_no_refresh();
        for (int i = 0; i < 200; i++) begin
            tick();
            checks++;
            if (dram_refresh !== 3'b000 || req_ready !== 1'b1 || ref_busy !== 1'b0) begin
                errors++;
                $display("FAIL no_refresh[%0d]: refresh=%b ready=%b busy=%b, required 000 1 0",
                         i, dram_refresh, req_ready, ref_busy);
            end
        end
    endtask
`else
    task automatic test_refresh_preempt();
        apply_reset();
        repeat (8) tick();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'h001;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL pre_ready: req_ready=%b, required 0", req_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dram_refresh !== 3'b001 || ref_busy !== 1'b1 || dram_cs !== 3'b001
                || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL pre_ref[%0d]: refresh=%b busy=%b cs=%b ready=%b, required 001 1 001 0",
                         i, dram_refresh, ref_busy, dram_cs, req_ready);
            end
        end
        tick();
        checks++;
        if (dram_refresh !== 3'b000 || ref_busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL pre_end: refresh=%b busy=%b ready=%b, required 000 0 1",
                     dram_refresh, ref_busy, req_ready);
        end
        record(1'b0, 10'h001, 32'd0);
        tick();
        req_valid = 1'b0;
        checks++;
        if ({dram_cs, dram_rw, dram_oe} !== {3'b001, 3'b001, 2'b01}) begin
            errors++;
            $display("FAIL pre_accept: cs=%b rw=%b oe=%b, required 001 001 01",
                     dram_cs, dram_rw, dram_oe);
        end
        drain("preempt");
    endtask

    task automatic test_refresh_during_read();
        apply_reset();
        repeat (7) tick();
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'h003;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rdref_ready: req_ready=%b, required 1", req_ready);
        end
        record(1'b0, 10'h003, 32'd0);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0 || ref_busy !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rdref_idle: pending=%0d busy=%b ready=%b, required 0 0 0",
                     exp_q.size(), ref_busy, req_ready);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ref_busy !== 1'b1 || dram_refresh !== 3'b001) begin
                errors++;
                $display("FAIL rdref_ref[%0d]: busy=%b refresh=%b, required 1 001",
                         i, ref_busy, dram_refresh);
            end
        end
        tick();
        checks++;
        if (ref_busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rdref_end: busy=%b ready=%b, required 0 1", ref_busy, req_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_reset_mid_read();
`ifndef DRAM_CTRL_REFRESH_EN
        test_no_refresh();
`else
        test_refresh_preempt();
        test_refresh_during_read();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
